// File: rtl/alu_pkg.sv
`default_nettype none
// alu_pkg: shared opcode, error-code and parser-state encodings for the ALU packet path.
package alu_pkg;

    typedef enum logic [7:0] {
        OPC_ADD  = 8'h10,
        OPC_MUL  = 8'h11,
        OPC_DIV  = 8'h12,
        OPC_ECHO = 8'hEC
    } opcode_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_OPCODE  = 2'd1,
        ERR_LEN     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

    // Encoding is visible on state_o, so keep values fixed.
    typedef enum logic [2:0] {
        ST_OPCODE  = 3'd0,
        ST_RSVD    = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_LEN_HI  = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_EMIT    = 3'd5,
        ST_DRAIN   = 3'd6
    } state_t;

    localparam logic [15:0] HDR_BYTES_C     = 16'd4;
    localparam logic [15:0] MIN_ARITH_LEN_C = 16'd12;
    localparam logic [15:0] MIN_ECHO_LEN_C  = 16'd5;

    function automatic logic is_arith(input logic [7:0] op);
        return (op == OPC_ADD) || (op == OPC_MUL) || (op == OPC_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_byte_packer.sv
`default_nettype none
// alu_byte_packer: gathers four bytes into a little-endian 32-bit word; done flags the completing byte.
module alu_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  data,
    output logic [31:0] word_next,
    output logic        done
);

    logic [31:0] word;
    logic [1:0]  idx;

    // Right shift puts the first byte in bits [7:0] after four loads.
    assign word_next = {data, word[31:8]};
    assign done      = load && (idx == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word <= 32'd0;
            idx  <= 2'd0;
        end else if (clear) begin
            word <= 32'd0;
            idx  <= 2'd0;
        end else if (load) begin
            word <= word_next;
            idx  <= idx + 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_packet_parser.sv
`default_nettype none
// alu_packet_parser: parses opcode/rsvd/len headers and emits 32-bit LE operands on a valid/ready stream.
// Define ALU_PARSER_TIMEOUT_EN to abort packets whose bytes stall for TIMEOUT_CYCLES_P cycles.
module alu_packet_parser
    import alu_pkg::*;
#(
    parameter logic [15:0] MAX_LEN_P        = 16'd1024,
    parameter logic [23:0] TIMEOUT_CYCLES_P = 24'd1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic [7:0]  opcode_o,
    output logic [15:0] op_count_o,
    output logic [31:0] operand_o,
    output logic        valid_o,
    output logic        last_o,
    input  logic        ready_i,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    output logic [2:0]  state_o
);

    state_t      state;
    err_code_t   err_code;
    logic [7:0]  opcode_q;
    logic [7:0]  len_lo;
    logic [15:0] remaining;
    logic [15:0] emit_idx;
    logic [15:0] len;
    logic        accept;
    logic        arith;
    logic        echo;
    logic        len_ok;
    logic        pk_clear;
    logic        pk_load;
    logic        pk_done;
    logic [31:0] pk_word;
    logic        timeout_fire;

    assign accept     = valid_i && ready_o;
    assign len        = {data_i, len_lo};
    assign arith      = is_arith(opcode_q);
    assign echo       = (opcode_q == OPC_ECHO);
    assign len_ok     = arith ? ((len >= MIN_ARITH_LEN_C) && (len[1:0] == 2'b00) && (len <= MAX_LEN_P))
                              : ((len >= MIN_ECHO_LEN_C) && (len <= MAX_LEN_P));
    assign state_o    = state;
    assign err_code_o = err_code;
    assign pk_clear   = ((state == ST_OPCODE) && accept) || timeout_fire;
    assign pk_load    = (state == ST_PAYLOAD) && accept && arith;

    alu_byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (pk_clear),
        .load      (pk_load),
        .data      (data_i),
        .word_next (pk_word),
        .done      (pk_done)
    );

`ifdef ALU_PARSER_TIMEOUT_EN
    logic [23:0] idle_cnt;
    logic        idle_run;

    assign idle_run     = (state != ST_OPCODE) && (state != ST_EMIT) && !accept;
    assign timeout_fire = idle_run && (idle_cnt == TIMEOUT_CYCLES_P - 24'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= 24'd0;
        end else if (!idle_run || timeout_fire) begin
            idle_cnt <= 24'd0;
        end else begin
            idle_cnt <= idle_cnt + 24'd1;
        end
    end
`else
    logic unused_timeout;
    assign timeout_fire   = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES_P;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_OPCODE;
            err_code   <= ERR_NONE;
            opcode_q   <= 8'd0;
            len_lo     <= 8'd0;
            remaining  <= 16'd0;
            emit_idx   <= 16'd0;
            ready_o    <= 1'b0;
            opcode_o   <= 8'd0;
            op_count_o <= 16'd0;
            operand_o  <= 32'd0;
            valid_o    <= 1'b0;
            last_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            err_o   <= 1'b0;
            ready_o <= 1'b1;
            if (timeout_fire) begin
                err_o    <= 1'b1;
                err_code <= ERR_TIMEOUT;
                valid_o  <= 1'b0;
                last_o   <= 1'b0;
                state    <= ST_OPCODE;
            end else begin
                case (state)
                    ST_OPCODE: if (accept) begin
                        opcode_q <= data_i;
                        state    <= ST_RSVD;
                    end
                    ST_RSVD: if (accept) begin
                        state <= ST_LEN_LO;
                    end
                    ST_LEN_LO: if (accept) begin
                        len_lo <= data_i;
                        state  <= ST_LEN_HI;
                    end
                    ST_LEN_HI: if (accept) begin
                        opcode_o <= opcode_q;
                        emit_idx <= 16'd0;
                        if (!(arith || echo) || !len_ok) begin
                            err_o      <= 1'b1;
                            err_code   <= (arith || echo) ? ERR_LEN : ERR_OPCODE;
                            op_count_o <= 16'd0;
                            // Short lengths have no body to drain.
                            if (len > HDR_BYTES_C) begin
                                remaining <= len - HDR_BYTES_C;
                                state     <= ST_DRAIN;
                            end else begin
                                state <= ST_OPCODE;
                            end
                        end else begin
                            op_count_o <= arith ? ((len - HDR_BYTES_C) >> 2) : (len - HDR_BYTES_C);
                            state      <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: if (accept && (echo || pk_done)) begin
                        operand_o <= echo ? {24'd0, data_i} : pk_word;
                        valid_o   <= 1'b1;
                        last_o    <= (emit_idx == op_count_o - 16'd1);
                        ready_o   <= 1'b0;
                        state     <= ST_EMIT;
                    end
                    ST_EMIT: begin
                        if (ready_i) begin
                            valid_o  <= 1'b0;
                            last_o   <= 1'b0;
                            emit_idx <= emit_idx + 16'd1;
                            state    <= last_o ? ST_OPCODE : ST_PAYLOAD;
                        end else begin
                            ready_o <= 1'b0;
                        end
                    end
                    ST_DRAIN: if (accept) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state <= ST_OPCODE;
                        end
                    end
                    default: state <= ST_OPCODE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_packet_parser.sv
`default_nettype none
// tb_alu_packet_parser: randomized packets, reference model feeding a scoreboard, decoupled monitor.
module tb_alu_packet_parser;

    localparam int MAX_LEN = 32;

    typedef struct {
        logic [31:0] operand;
        logic        last;
        logic [7:0]  opc;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        ready_o;
    logic [7:0]  opcode_o;
    logic [15:0] op_count_o;
    logic [31:0] operand_o;
    logic        valid_o;
    logic        last_o;
    logic        ready_i = 1'b0;
    logic        err_o;
    logic [1:0]  err_code_o;
    logic [2:0]  state_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   bp_hold  = 0;
    exp_t exp_q[$];
    int   err_q[$];
    logic [7:0] pkt[$];
    int   bad_arith[6] = '{8, 10, 13, 36, 4, 2};
    int   bad_echo[4]  = '{4, 3, 33, 0};

    alu_packet_parser #(.MAX_LEN_P(16'd32), .TIMEOUT_CYCLES_P(24'd50)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .opcode_o   (opcode_o),
        .op_count_o (op_count_o),
        .operand_o  (operand_o),
        .valid_o    (valid_o),
        .last_o     (last_o),
        .ready_i    (ready_i),
        .err_o      (err_o),
        .err_code_o (err_code_o),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: derives the outcome of a whole packet from its header rules.
    task automatic model_pkt();
        logic [7:0] op;
        int len, n;
        bit arith, echo;
        exp_t e;
        op    = pkt[0];
        len   = {16'd0, pkt[3], pkt[2]};
        arith = (op == 8'h10) || (op == 8'h11) || (op == 8'h12);
        echo  = (op == 8'hEC);
        if (!arith && !echo) begin
            err_q.push_back(1);
        end else if (arith && !(len >= 12 && len % 4 == 0 && len <= MAX_LEN)) begin
            err_q.push_back(2);
        end else if (echo && !(len >= 5 && len <= MAX_LEN)) begin
            err_q.push_back(2);
        end else begin
            n = arith ? (len - 4) / 4 : len - 4;
            for (int i = 0; i < n; i++) begin
                if (arith)
                    e.operand = pkt[4+4*i] + (pkt[5+4*i] << 8) + (pkt[6+4*i] << 16) + (pkt[7+4*i] << 24);
                else
                    e.operand = {24'd0, pkt[4+i]};
                e.last = (i == n - 1);
                e.opc  = op;
                e.cnt  = 16'(n);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic build_pkt(input logic [7:0] op, input int len);
        pkt.delete();
        pkt.push_back(op);
        pkt.push_back(8'($urandom));
        pkt.push_back(len[7:0]);
        pkt.push_back(len[15:8]);
        for (int i = 4; i < len; i++) pkt.push_back(8'($urandom));
    endtask

    task automatic gen_pkt(input int kind);
        logic [7:0] op;
        int len;
        case (kind)
            0: begin op = 8'h10 + 8'($urandom_range(0, 2)); len = 4 + 4 * int'($urandom_range(2, 7)); end
            1: begin op = 8'hEC; len = 4 + int'($urandom_range(1, 8)); end
            2: begin
                do op = 8'($urandom); while (op == 8'h10 || op == 8'h11 || op == 8'h12 || op == 8'hEC);
                len = int'($urandom_range(0, 12));
            end
            3: begin op = 8'h10 + 8'($urandom_range(0, 2)); len = bad_arith[$urandom_range(0, 5)]; end
            default: begin op = 8'hEC; len = bad_echo[$urandom_range(0, 3)]; end
        endcase
        build_pkt(op, len);
    endtask

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        bit r;
        valid_i = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        data_i  = b;
        valid_i = 1'b1;
        guard   = 0;
        do begin
            r = ready_o;
            @(negedge clk);
            guard++;
        end while (!r && guard < 5000);
        if (!r) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_accept: ready_o stayed 0, required 1");
        end
        valid_i = 1'b0;
    endtask

    task automatic run_pkt();
        model_pkt();
        foreach (pkt[i]) send_byte(pkt[i]);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((exp_q.size() != 0 || err_q.size() != 0 || state_o != 3'd0) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("drain_to_idle", {32'(exp_q.size()), 29'd0, state_o}, 64'd0);
    endtask

    // Monitor: drives ready_i and scores every operand and error the DUT presents.
    initial begin : monitor
        bit          pend = 0;
        logic [31:0] p_op = '0;
        logic        p_last = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend    = 0;
                ready_i = 1'b0;
                continue;
            end
            if (bp_hold > 0) begin
                ready_i = 1'b0;
                if (valid_o) bp_hold--;
            end else begin
                ready_i = ($urandom_range(0, 3) != 0);
            end
            if (valid_o) begin
                if (pend) check("hold_stable", {31'd0, ready_o, last_o, operand_o}, {31'd0, 1'b0, p_last, p_op});
                if (ready_i) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_operand: got %h, required no operand", operand_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("operand", {7'd0, opcode_o, op_count_o, last_o, operand_o},
                              {7'd0, e.opc, e.cnt, e.last, e.operand});
                    end
                    pend = 0;
                end else begin
                    pend   = 1;
                    p_op   = operand_o;
                    p_last = last_o;
                end
            end else begin
                pend = 0;
            end
            if (err_o) begin
                if (err_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_err: got code %0d, required no error", err_code_o);
                end else begin
                    check("err_code", 64'(err_code_o), 64'(err_q.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst     = 1'b0;
        valid_i = 1'b0;
        data_i  = 8'd0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_ctrl", {26'd0, ready_o, valid_o, last_o, err_o, err_code_o, state_o, opcode_o, op_count_o},
              64'd0);
        check("reset_operand", 64'(operand_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        pkt = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        run_pkt();
        pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
        run_pkt();
        pkt = '{8'h55, 8'h00, 8'h08, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_pkt();
        pkt = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_pkt();
        pkt = '{8'h11, 8'h00, 8'h0A, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_pkt();
        wait_idle();
        check("err_code_holds", 64'(err_code_o), 64'd2);

        bp_hold = 20;
        build_pkt(8'h10, 12);
        run_pkt();
        wait_idle();

        repeat (60) begin
            gen_pkt(int'($urandom_range(0, 4)));
            run_pkt();
        end
        build_pkt(8'h12, 32); run_pkt();
        build_pkt(8'hEC, 32); run_pkt();
        build_pkt(8'h11, 36); run_pkt();
        build_pkt(8'hEC, 33); run_pkt();
        build_pkt(8'hEC, 2);  run_pkt();
        wait_idle();

        build_pkt(8'h10, 12);
        for (int i = 0; i < 6; i++) send_byte(pkt[i]);
        rst = 1'b0;
        #1;
        check("midpkt_reset_ctrl", {26'd0, ready_o, valid_o, last_o, err_o, err_code_o, state_o, opcode_o, op_count_o},
              64'd0);
        check("midpkt_reset_operand", 64'(operand_o), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        build_pkt(8'hEC, 6);
        run_pkt();
        wait_idle();

`ifdef ALU_PARSER_TIMEOUT_EN
        pkt = '{8'h10, 8'h00, 8'h0C};
        err_q.push_back(3);
        foreach (pkt[i]) send_byte(pkt[i]);
        repeat (60) @(negedge clk);
        check("timeout", {32'(err_q.size()), 27'd0, err_code_o, state_o}, {32'd0, 27'd0, 2'd3, 3'd0});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
